// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the F/D/E/W datapath.
// It handles stage enables and flushes, load-use stalls, operand forwarding and the multi-cycle unit handshake.
module pipe_hazard_ctrl #(
    parameter int R          = 5,
    parameter int MC_TIMEOUT = 64,
    parameter int CW         = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          valid_d_i,
    input  logic [R-1:0]  rs_addr_d_i,
    input  logic [R-1:0]  rt_addr_d_i,
    input  logic          rs_used_d_i,
    input  logic          rt_used_d_i,
    input  logic [R-1:0]  rd_addr_e_i,
    input  logic          rd_we_e_i,
    input  logic          is_load_e_i,
    input  logic          mc_op_e_i,
    input  logic [R-1:0]  rd_addr_w_i,
    input  logic          rd_we_w_i,
    input  logic          branch_taken_e_i,
    input  logic          mc_done_i,
    output logic          en_f_o,
    output logic          en_d_o,
    output logic          en_e_o,
    output logic          flush_d_o,
    output logic          flush_e_o,
    output logic [1:0]    fwd_rs_o,
    output logic [1:0]    fwd_rt_o,
    output logic          mc_start_o,
    output logic          mc_busy_o,
    output logic          mc_err_o,
    output logic [CW-1:0] stall_cnt_o
);

    localparam int TW = $clog2(MC_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          mcErr_q, mcErr_d;
    logic [CW-1:0] stallCnt_q;

    logic eWrites, wWrites;
    logic matchRsE, matchRtE, matchRsW, matchRtW;
    logic loadUse;

    // Register 0 is hardwired zero, so a write to it never produces a hazard or a forward.
    assign eWrites  = rd_we_e_i && (rd_addr_e_i != '0);
    assign wWrites  = rd_we_w_i && (rd_addr_w_i != '0);
    assign matchRsE = eWrites && (rd_addr_e_i == rs_addr_d_i);
    assign matchRtE = eWrites && (rd_addr_e_i == rt_addr_d_i);
    assign matchRsW = wWrites && (rd_addr_w_i == rs_addr_d_i);
    assign matchRtW = wWrites && (rd_addr_w_i == rt_addr_d_i);

    assign loadUse = valid_d_i && is_load_e_i &&
                     ((rs_used_d_i && matchRsE) || (rt_used_d_i && matchRtE));

    always_comb begin
        fwd_rs_o = 2'b00;
        fwd_rt_o = 2'b00;
        if (matchRsE && !is_load_e_i) begin
            fwd_rs_o = 2'b01;
        end else if (matchRsW) begin
            fwd_rs_o = 2'b10;
        end
        if (matchRtE && !is_load_e_i) begin
            fwd_rt_o = 2'b01;
        end else if (matchRtW) begin
            fwd_rt_o = 2'b10;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        mcErr_d    = mcErr_q;
        en_f_o     = 1'b1;
        en_d_o     = 1'b1;
        en_e_o     = 1'b1;
        flush_d_o  = 1'b0;
        flush_e_o  = 1'b0;
        mc_start_o = 1'b0;
        mc_busy_o  = 1'b0;
        unique case (state_q)
            MC_WAIT: begin
                mc_busy_o = 1'b1;
                en_f_o    = 1'b0;
                en_d_o    = 1'b0;
                en_e_o    = 1'b0;
                timer_d   = timer_q + TW'(1);
                // A done arriving on the timeout cycle wins, so no error is flagged.
                if (mc_done_i) begin
                    state_d = DONE;
                end else if (timer_q == TW'(MC_TIMEOUT - 1)) begin
                    mcErr_d = 1'b1;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = RUN;
                if (branch_taken_e_i) begin
                    flush_d_o = 1'b1;
                    flush_e_o = 1'b1;
                end else if (mc_op_e_i && (state_q == RUN)) begin
                    mc_start_o = 1'b1;
                    en_f_o     = 1'b0;
                    en_d_o     = 1'b0;
                    en_e_o     = 1'b0;
                    timer_d    = '0;
                    state_d    = MC_WAIT;
                end else if (loadUse) begin
                    en_f_o    = 1'b0;
                    en_d_o    = 1'b0;
                    flush_e_o = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            timer_q <= '0;
            mcErr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            mcErr_q <= mcErr_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stallCnt_q <= '0;
        end else if (!en_d_o && (stallCnt_q != '1)) begin
            stallCnt_q <= stallCnt_q + CW'(1);
        end
    end

    assign mc_err_o    = mcErr_q;
    assign stall_cnt_o = stallCnt_q;

endmodule
